regfile_wr_arbiter: RTL
=======================

// Module: regfile_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of the register bank (one
//  dflipflop_en word per address) between NREQ requesters (ALU writeback, load
//  unit, link/JAL, debug). Grants at most one requester per cycle. Drives the
//  bank's one-hot word enables and the shared write data. Supports short locked
//  bursts so that a requester can hold the port.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  WIDTH     32  register word width
//  ADDRW     5   address width; bank depth = 2**ADDRW
//  MAX_HOLD  4   max consecutive cycles one requester may keep the port via lock
// PORTS
//  clk       in   1             rising-edge clock
//  reset     in   1             synchronous, active-high
//  req       in   NREQ          request per requester
//  lock      in   NREQ          hold request; only honoured for the current grantee
//  wr_addr   in   NREQ*ADDRW    flat; requester i at [i*ADDRW +: ADDRW]
//  wr_data   in   NREQ*WIDTH    flat; requester i at [i*WIDTH +: WIDTH]
//  grant     out  NREQ          registered one-hot (or zero) grant
//  word_en   out  2**ADDRW      registered one-hot enable to the bank's word `en` pins
//  d_out     out  WIDTH         registered write data to all bank words
//  busy      out  1             1 while in state HOLD
// BEHAVIOUR
//  - Reset (sync, on the edge with reset=1): grant=0, word_en=0, d_out=0, busy=0,
//    state=IDLE, rr_ptr=0, hold_cnt=0. Reset has priority over every other event, including mid-burst.
//  - Latency: req sampled at edge t -> grant/word_en/d_out valid after edge t+1
//    (1 cycle). The bank captures d_out at edge t+2. Ports are all registered, with no comb path from input to output.
//  - Selection: search starts at rr_ptr and wraps modulo NREQ; the first asserted
//    req wins. After a grant to i, rr_ptr <= (i+1) mod NREQ.
//  - word_en = one-hot decode of the winner's wr_addr; d_out = winner's wr_data.
//    No winner -> grant=0, word_en=0, d_out holds its previous value.
//  - States:
//    IDLE : no grant. Any req -> GRANT (winner chosen as above).
//    GRANT: one write issued. If grantee has req&lock -> HOLD, hold_cnt<=1;
//           else re-arbitrate (-> GRANT if any req, else IDLE).
//    HOLD : grantee keeps the port; wr_addr/wr_data are resampled each cycle.
//           hold_cnt increments each cycle. Leave HOLD when lock or req drops, or
//           when hold_cnt==MAX_HOLD-1. The next grant then goes to the next requester
//           in round-robin order. If no other requester is waiting, the same
//           requester may be re-granted, but only through a fresh GRANT.
//  - lock from a non-grantee is ignored. lock without req is ignored.
//  - If the grantee drops req during HOLD, no write occurs that cycle (word_en=0).
//  - Simultaneous reqs from all NREQ: each gets one grant in every NREQ-cycle window.
//  - Total grant cycles per burst <= MAX_HOLD (GRANT + HOLD cycles).
// CONFIGURATION
//  `REGFILE_ZERO_GUARD_EN defined: a winning write to address 0 still asserts
//    grant and advances rr_ptr, but forces word_en=0 (hardwired $zero register).
//  Undefined: address 0 is writable like any other word.
// TESTING
//  1 reset=1 for 2 cycles with req=4'b1111 -> grant=0, word_en=0, d_out=0, busy=0.
//  2 req=4'b0100, wr_addr[2]=5'd7, wr_data[2]=32'hDEADBEEF -> next cycle grant=4'b0100,
//    word_en=1<<7, d_out=32'hDEADBEEF; bank word 7 reads DEADBEEF after one more edge.
//  3 req=4'b1111 held for 8 cycles, no lock -> grant sequence 0001,0010,0100,1000,
//    0001,0010,0100,1000.
//  4 req=4'b0011, lock=4'b0001, MAX_HOLD=4 -> grant=0001 for 4 cycles, busy=1 on
//    cycles 2-4, then grant=0010.
//  5 reset asserted on the 2nd cycle of a HOLD burst -> all outputs 0 next cycle,
//    rr_ptr=0; with req=4'b1010 after reset the first grant=0010.
//  6 wr_addr=0, req=4'b0001: with REGFILE_ZERO_GUARD_EN -> grant=0001, word_en=0;
//    without it -> word_en=32'h1.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter_if
// Bundles the requester-side write bus and the arbiter's registered results
// for the shared register-bank write port.
//   req      requester request bits (NREQ)
//   lock     requester hold-the-port bits (NREQ)
//   wr_addr  flat addresses, requester i at [i*ADDRW +: ADDRW]
//   wr_data  flat data, requester i at [i*WIDTH +: WIDTH]
//   grant    one-hot (or zero) grant
//   word_en  one-hot bank word enable (2**ADDRW)
//   d_out    write data shared by all bank words
//   busy     port held by a locked burst
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface regfile_wr_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ADDRW = 5
);
   localparam int unsigned DEPTH = 2 ** ADDRW;

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       lock;
   logic [NREQ*ADDRW-1:0] wr_addr;
   logic [NREQ*WIDTH-1:0] wr_data;
   logic [NREQ-1:0]       grant;
   logic [DEPTH-1:0]      word_en;
   logic [WIDTH-1:0]      d_out;
   logic                  busy;

   modport master (
      output req, lock, wr_addr, wr_data,
      input  grant, word_en, d_out, busy
   );

   modport slave (
      input  req, lock, wr_addr, wr_data,
      output grant, word_en, d_out, busy
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter
// Round-robin arbiter for the single write port of the register bank. Grants
// at most one requester per cycle, drives the bank's one-hot word enables and
// shared write data, and lets the grantee hold the port for a short locked
// burst (at most MAX_HOLD grant cycles in total).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    regfile_wr_arbiter_if.slave (req/lock/wr_addr/wr_data in,
//          grant/word_en/d_out/busy out, all outputs registered)
// Optional feature: define REGFILE_ZERO_GUARD_EN to suppress the word enable
// for writes to address 0 (hardwired zero register); grant and round-robin
// advance are unaffected.
// ----------------------------------------------------------------------------
module regfile_wr_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ADDRW    = 5,
   parameter int unsigned MAX_HOLD = 4
) (
   input logic                 clk,
   input logic                 reset,
   regfile_wr_arbiter_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDRW;
   localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned HW    = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    rr_ptr, rr_nxt;
   logic [PW-1:0]    gnt_idx, gnt_idx_nxt;
   logic [HW-1:0]    hold_cnt, hold_nxt;
   logic [NREQ-1:0]  grant_q, grant_nxt;
   logic [DEPTH-1:0] word_en_q, word_en_nxt;
   logic [WIDTH-1:0] d_out_q, d_out_nxt;
   logic             busy_q, busy_nxt;

   logic [ADDRW-1:0] addr_a [NREQ];
   logic [WIDTH-1:0] data_a [NREQ];

   logic             win_found;
   logic [PW-1:0]    win_idx;
   logic [PW-1:0]    cand;
   logic             do_arb;
   logic             sel_valid;
   logic [PW-1:0]    sel_idx;
   logic [ADDRW-1:0] sel_addr;

   // Unpack the flat per-requester address/data buses.
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_a[g] = bus.wr_addr[g*ADDRW +: ADDRW];
      assign data_a[g] = bus.wr_data[g*WIDTH +: WIDTH];
   end

   // Round-robin search: first asserted req at or after rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = PW'((32'(rr_ptr) + k) % NREQ);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt   = state;
      rr_nxt      = rr_ptr;
      gnt_idx_nxt = gnt_idx;
      hold_nxt    = hold_cnt;
      grant_nxt   = '0;
      word_en_nxt = '0;
      d_out_nxt   = d_out_q;
      busy_nxt    = 1'b0;
      do_arb      = 1'b0;
      sel_valid   = 1'b0;
      sel_idx     = gnt_idx;
      sel_addr    = '0;

      case (state)
         IDLE: do_arb = 1'b1;
         GRANT: begin
            // A single-cycle budget leaves no room for a HOLD cycle.
            if (bus.req[gnt_idx] && bus.lock[gnt_idx] && (MAX_HOLD > 1)) begin
               state_nxt = HOLD;
               hold_nxt  = HW'(1);
               sel_valid = 1'b1;
            end else begin
               do_arb = 1'b1;
            end
         end
         HOLD: begin
            if (bus.req[gnt_idx] && bus.lock[gnt_idx] &&
                (hold_cnt < HW'(MAX_HOLD - 1))) begin
               hold_nxt  = hold_cnt + HW'(1);
               sel_valid = 1'b1;
            end else begin
               do_arb = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // rr_ptr already points past the grantee, so a released burst goes to
      // the next requester and only re-grants the same one if it is alone.
      if (do_arb) begin
         hold_nxt = '0;
         if (win_found) begin
            state_nxt = GRANT;
            sel_valid = 1'b1;
            sel_idx   = win_idx;
            rr_nxt    = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
         end else begin
            state_nxt = IDLE;
         end
      end

      if (sel_valid) begin
         sel_addr             = addr_a[sel_idx];
         gnt_idx_nxt          = sel_idx;
         grant_nxt[sel_idx]   = 1'b1;
         d_out_nxt            = data_a[sel_idx];
         word_en_nxt          = DEPTH'(1) << sel_addr;
`ifdef REGFILE_ZERO_GUARD_EN
         if (sel_addr == '0) begin
            word_en_nxt = '0;
         end
`else
`endif
      end

      busy_nxt = (state_nxt == HOLD);
   end

   // State and output registers; reset overrides everything, including bursts.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         gnt_idx   <= '0;
         hold_cnt  <= '0;
         grant_q   <= '0;
         word_en_q <= '0;
         d_out_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_nxt;
         gnt_idx   <= gnt_idx_nxt;
         hold_cnt  <= hold_nxt;
         grant_q   <= grant_nxt;
         word_en_q <= word_en_nxt;
         d_out_q   <= d_out_nxt;
         busy_q    <= busy_nxt;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.word_en = word_en_q;
   assign bus.d_out   = d_out_q;
   assign bus.busy    = busy_q;
endmodule
